// File: rtl/rf_gpio_responder.sv
// rf_gpio_responder
//   Command responder behind a processor GPIO pair. The processor writes a
//   command word on i_gpo and raises the enable bit; the block executes the
//   command once per enable rising edge and answers on o_gpi with the echoed
//   command, a toggling ack bit and the result data.
//
// Ports
//   clock        : block clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_gpo        : [31:24] command, [23] enable, [22:0] payload
//   o_gpi        : [31:24] echoed command, [23] ack toggle, [22:0] read data
//   o_ctrl       : live copy of register 0
//   o_cfg        : live copy of register 1
//   o_soft_reset : one-cycle pulse while a SOFT_RESET command executes
//   o_busy       : high whenever the FSM is not in IDLE
module rf_gpio_responder #(
    parameter int NB_GPIOS = 32,
    parameter int NB_DATA  = 23,
    parameter int N_REGS   = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_GPIOS-1:0] i_gpo,
    output logic [NB_GPIOS-1:0] o_gpi,
    output logic [NB_DATA-1:0]  o_ctrl,
    output logic [NB_DATA-1:0]  o_cfg,
    output logic                o_soft_reset,
    output logic                o_busy
);

    localparam int AW = $clog2(N_REGS);

    localparam logic [7:0] CMD_SET_ADDR   = 8'h01;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam logic [7:0] CMD_SOFT_RESET = 8'h04;
    localparam logic [7:0] CMD_READ_CNT   = 8'h05;

    typedef enum logic [1:0] {IDLE, EXEC, RESP, WAIT_LOW} state_t;

    state_t               state_q;
    logic                 en_prev_q;
    logic [7:0]           cmd_q;
    logic [NB_DATA-1:0]   payload_q;
    logic [NB_DATA-1:0]   rdata_q;
    logic [AW-1:0]        addr_q;
    logic [NB_DATA-1:0]   regs_q [N_REGS];
    logic [NB_DATA-1:0]   cnt_q;
    logic [NB_DATA-1:0]   cnt_d;
    logic                 ack_q;
    logic [NB_GPIOS-1:0]  gpi_q;
    logic                 soft_q;

    logic       en;
    logic [7:0] cmd_in;
    logic       accept;

    assign en     = i_gpo[NB_DATA];
    assign cmd_in = i_gpo[NB_GPIOS-1 -: 8];
    // Only a low->high transition of enable starts a command.
    assign accept = (state_q == IDLE) && en && !en_prev_q;
    assign cnt_d  = cnt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            // Reset high so an enable held through reset is not seen as an edge.
            en_prev_q <= 1'b1;
            cmd_q     <= '0;
            payload_q <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            gpi_q     <= '0;
            soft_q    <= 1'b0;
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            en_prev_q <= en;
            soft_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_q     <= cmd_in;
                        payload_q <= i_gpo[NB_DATA-1:0];
                        // Pulse is registered here so it is high exactly during EXEC.
                        soft_q    <= (cmd_in == CMD_SOFT_RESET);
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    case (cmd_q)
                        CMD_SET_ADDR: begin
                            addr_q  <= payload_q[AW-1:0];
                            rdata_q <= NB_DATA'(payload_q[AW-1:0]);
                        end
                        CMD_WRITE: begin
                            regs_q[addr_q] <= payload_q;
                            rdata_q        <= payload_q;
                        end
                        CMD_READ: rdata_q <= regs_q[addr_q];
                        CMD_SOFT_RESET: begin
                            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
                            addr_q  <= '0;
                            rdata_q <= '0;
                        end
                        CMD_READ_CNT: rdata_q <= cnt_q;
                        default: rdata_q <= '1;
                    endcase
                    state_q <= RESP;
                end
                RESP: begin
                    gpi_q   <= NB_GPIOS'({cmd_q, ~ack_q, rdata_q});
                    ack_q   <= ~ack_q;
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gpi        = gpi_q;
    assign o_ctrl       = regs_q[0];
    assign o_cfg        = regs_q[1];
    assign o_soft_reset = soft_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rf_gpio_responder.sv
// Directed bench: a register/address/ack model predicts each response at the
// moment a command is driven (pushed to a queue) and the response is popped
// and compared when it is due on o_gpi.
module tb_rf_gpio_responder;

    logic        clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic [22:0] o_ctrl, o_cfg;
    logic        o_soft_reset, o_busy;

    // Narrow instance so counter wrap is reachable in a short run.
    logic [16:0] s_gpo, s_gpi;
    logic [7:0]  s_ctrl, s_cfg;
    logic        s_soft, s_busy;

    always #5 clock = ~clock;

    rf_gpio_responder dut (
        .clock(clock), .i_reset(i_reset), .i_gpo(i_gpo), .o_gpi(o_gpi),
        .o_ctrl(o_ctrl), .o_cfg(o_cfg), .o_soft_reset(o_soft_reset), .o_busy(o_busy)
    );

    rf_gpio_responder #(.NB_GPIOS(17), .NB_DATA(8), .N_REGS(8)) u_small (
        .clock(clock), .i_reset(i_reset), .i_gpo(s_gpo), .o_gpi(s_gpi),
        .o_ctrl(s_ctrl), .o_cfg(s_cfg), .o_soft_reset(s_soft), .o_busy(s_busy)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;           // non-reset clock edges since last reset
    logic [31:0] exp_q[$];
    logic [22:0] treg[8];
    logic [2:0]  taddr;
    logic        tack;
    logic [31:0] last_gpi;

    always @(posedge clock) begin
        if (i_reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) treg[i] = '0;
        taddr    = '0;
        tack     = 1'b0;
        last_gpi = '0;
        exp_q.delete();
    endtask

    task automatic do_reset(input logic en);
        @(negedge clock);
        i_reset = 1'b1;
        i_gpo   = {8'h00, en, 23'h0};
        s_gpo   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        i_reset = 1'b0;
        model_clear();
    endtask

    // Issue one command. early=1 drops enable during EXEC; hold keeps enable
    // high for extra cycles after the response.
    task automatic send(input logic [7:0] op, input logic [22:0] d,
                        input logic early, input int hold);
        logic [22:0] e;
        logic [22:0] ctrl_old;
        logic [31:0] exp;
        @(negedge clock);
        i_gpo    = {op, 1'b1, d};
        ctrl_old = treg[0];
        case (op)
            8'h01: begin taddr = d[2:0]; e = {20'b0, taddr}; end
            8'h02: begin treg[taddr] = d; e = d; end
            8'h03: e = treg[taddr];
            8'h04: begin
                for (int i = 0; i < 8; i++) treg[i] = '0;
                taddr = '0;
                e = '0;
            end
            8'h05: e = 23'(cyc + 1);
            default: e = 23'h7FFFFF;
        endcase
        tack = ~tack;
        exp_q.push_back({op, tack, e});

        @(posedge clock); #1;
        chk("busy_exec", {31'b0, o_busy}, 32'd1);
        chk("soft_pulse_exec", {31'b0, o_soft_reset}, {31'b0, op == 8'h04});
        chk("ctrl_before_exec", {9'b0, o_ctrl}, {9'b0, ctrl_old});
        // Accepted command must be insensitive to later input changes.
        i_gpo = {~op, ~early, ~d};

        @(posedge clock); #1;
        chk("soft_pulse_resp", {31'b0, o_soft_reset}, 32'd0);
        chk("gpi_not_early", o_gpi, last_gpi);
        chk("ctrl_after_exec", {9'b0, o_ctrl}, {9'b0, treg[0]});
        chk("cfg_after_exec", {9'b0, o_cfg}, {9'b0, treg[1]});

        @(posedge clock); #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("gpi_resp", o_gpi, exp);
            last_gpi = exp;
        end
        chk("busy_wait_low", {31'b0, o_busy}, 32'd1);

        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            chk("gpi_single_ack", o_gpi, last_gpi);
        end

        @(negedge clock);
        i_gpo = '0;
        @(posedge clock); #1;
        chk("busy_idle", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] se;
        i_reset = 1'b1;
        i_gpo   = '0;
        s_gpo   = '0;
        do_reset(1'b0);
        chk("rst_gpi", o_gpi, 32'h0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_soft", {31'b0, o_soft_reset}, 32'd0);
        chk("rst_ctrl", {9'b0, o_ctrl}, 32'd0);
        chk("rst_cfg", {9'b0, o_cfg}, 32'd0);

        // SET_ADDR 2, WRITE 0x123456, READ back
        send(8'h01, 23'h000002, 1'b0, 0);
        send(8'h02, 23'h123456, 1'b0, 0);
        send(8'h03, 23'h000000, 1'b0, 0);
        // registers 0 and 1 drive o_ctrl / o_cfg
        send(8'h01, 23'h000000, 1'b0, 0);
        send(8'h02, 23'h00000F, 1'b0, 0);
        send(8'h01, 23'h000001, 1'b0, 0);
        send(8'h02, 23'h2AAAAA, 1'b0, 0);
        send(8'h01, 23'h7FFFFA, 1'b0, 0);   // address taken from low bits only
        send(8'h03, 23'h000000, 1'b0, 0);
        // SOFT_RESET clears everything, then reads return 0
        send(8'h04, 23'h1ABCDE, 1'b0, 0);
        send(8'h03, 23'h000000, 1'b0, 0);
        send(8'h01, 23'h000002, 1'b0, 0);
        send(8'h03, 23'h000000, 1'b0, 0);
        // unknown codes, enable held high 10 cycles
        send(8'h7E, 23'h001234, 1'b0, 10);
        send(8'h00, 23'h000000, 1'b0, 0);
        // enable falls during EXEC; counter read
        send(8'h05, 23'h000000, 1'b1, 0);
        send(8'h02, 23'h0000AA, 1'b1, 0);
        send(8'h03, 23'h000000, 1'b0, 0);

        // Reset lands on the EXEC edge of a WRITE, enable held through reset
        @(negedge clock);
        i_gpo = {8'h02, 1'b1, 23'h000055};
        @(posedge clock);
        do_reset(1'b1);
        repeat (5) begin
            @(posedge clock); #1;
            chk("held_en_no_cmd", {31'b0, o_busy}, 32'd0);
        end
        chk("rst_mid_gpi", o_gpi, 32'h0);
        chk("rst_mid_ctrl", {9'b0, o_ctrl}, 32'd0);
        @(negedge clock);
        i_gpo = '0;
        @(posedge clock);
        send(8'h03, 23'h000000, 1'b0, 0);   // ack restarts at 1
        send(8'h05, 23'h000000, 1'b0, 0);

        // narrow instance: 8-bit counter has wrapped by now
        repeat (300) @(posedge clock);
        @(negedge clock);
        s_gpo = {8'h05, 1'b1, 8'h00};
        se    = 8'((cyc + 1) % 256);
        repeat (3) @(posedge clock);
        #1;
        chk("wrap_no_x", {31'b0, $isunknown(s_gpi)}, 32'd0);
        chk("wrap_counter", {15'b0, s_gpi}, {15'b0, 8'h05, 1'b1, se});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
